// File: rtl/exe_issue_select_pkg.sv
// Shared constants and types for the EXE oldest-first issue selector.
package exe_issue_select_pkg;

  // Default ALU occupancy of a mult/div/HI-LO op, in cycles.
  localparam int MULDIV_LAT_DEF = 4;

  // ALU_Control codes of the mult/div/HI-LO class; decode ORs these into Req_MulDiv_IN.
  localparam logic [5:0] ALU_MULT  = 6'b000101;
  localparam logic [5:0] ALU_MULTU = 6'b000110;
  localparam logic [5:0] ALU_DIV   = 6'b001001;
  localparam logic [5:0] ALU_DIVU  = 6'b001010;
  localparam logic [5:0] ALU_MFHI  = 6'b001011;
  localparam logic [5:0] ALU_MFLO  = 6'b001100;
  localparam logic [5:0] ALU_MTHI  = 6'b001101;

  // Issue controller state: IDLE while the ALU is free, BUSY while a mult/div occupies it.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } issue_state_e;

  // Classify an ALU_Control code as a multi-cycle mult/div/HI-LO op.
  function automatic logic is_muldiv_op(input logic [5:0] alu_ctl);
    return (alu_ctl == ALU_MULT) || (alu_ctl == ALU_MULTU) || (alu_ctl == ALU_DIV) ||
           (alu_ctl == ALU_DIVU) || (alu_ctl == ALU_MFHI)  || (alu_ctl == ALU_MFLO) ||
           (alu_ctl == ALU_MTHI);
  endfunction

endpackage

// File: rtl/exe_issue_select_age_older.sv
// Wrap-safe age compare: age_a is older than age_b when (age_a - age_b) is negative.
module age_older
  import exe_issue_select_pkg::*;
#(
  parameter int AGE_W = 32
) (
  input  logic [AGE_W-1:0] age_a,
  input  logic [AGE_W-1:0] age_b,
  output logic             a_older
);

  localparam logic signed [AGE_W-1:0] ZERO = '0;

  logic signed [AGE_W-1:0] diff;

  assign diff    = signed'(age_a - age_b);
  assign a_older = (diff < ZERO);

endmodule

// File: rtl/exe_issue_select.sv
// Oldest-first issue selector for the single EXE unit, with mult/div occupancy blocking.
module exe_issue_select
  import exe_issue_select_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int AGE_W      = 32,
  parameter  int MULDIV_LAT = MULDIV_LAT_DEF,
  localparam int SEL_W      = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(MULDIV_LAT) + 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_REQ-1:0]       Req_Valid_IN,
  input  logic [NUM_REQ*AGE_W-1:0] Req_Age_IN,
  input  logic [NUM_REQ-1:0]       Req_MulDiv_IN,
  input  logic                     IF_stall_request,
  input  logic                     Flush_IN,
  output logic [NUM_REQ-1:0]       Grant_OUT,
  output logic                     Issue_Valid_OUT,
  output logic [SEL_W-1:0]         Issue_Sel_OUT,
  output logic [AGE_W-1:0]         Issue_Age_OUT,
  output logic                     Busy_OUT
);

  // Linear oldest-first reduction; a later requester only replaces the
  // running best when strictly older, so equal ages keep the lower index.
  logic               best_vld   [NUM_REQ];
  logic [SEL_W-1:0]   best_idx   [NUM_REQ];
  logic [AGE_W-1:0]   best_age   [NUM_REQ];
  logic [NUM_REQ-2:0] cand_older;

  assign best_vld[0] = Req_Valid_IN[0];
  assign best_idx[0] = '0;
  assign best_age[0] = Req_Age_IN[0 +: AGE_W];

  for (genvar k = 1; k < NUM_REQ; k++) begin : g_chain
    logic take;

    age_older #(.AGE_W(AGE_W)) u_older (
      .age_a   (Req_Age_IN[k*AGE_W +: AGE_W]),
      .age_b   (best_age[k-1]),
      .a_older (cand_older[k-1])
    );

    assign take        = Req_Valid_IN[k] && (!best_vld[k-1] || cand_older[k-1]);
    assign best_vld[k] = best_vld[k-1] | Req_Valid_IN[k];
    assign best_idx[k] = take ? SEL_W'(k) : best_idx[k-1];
    assign best_age[k] = take ? Req_Age_IN[k*AGE_W +: AGE_W] : best_age[k-1];
  end

  logic             any_vld;
  logic [SEL_W-1:0] win_idx;
  logic [AGE_W-1:0] win_age;
  logic             win_muldiv;

  assign any_vld    = best_vld[NUM_REQ-1];
  assign win_idx    = best_idx[NUM_REQ-1];
  assign win_age    = best_age[NUM_REQ-1];
  assign win_muldiv = Req_MulDiv_IN[win_idx];

  issue_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue_ok;

  // State register: occupancy state and remaining busy cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: flush releases the ALU, stall freezes the count, BUSY counts down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (Flush_IN) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (!IF_stall_request) begin
      case (state_q)
        ST_IDLE: begin
          if (issue_ok && win_muldiv && (MULDIV_LAT > 1)) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(MULDIV_LAT - 1);
          end
        end
        ST_BUSY: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode: one-hot grant only when nothing blocks issue.
  always_comb begin
    Busy_OUT  = (cnt_q != '0);
    issue_ok  = !RESET && !Flush_IN && !IF_stall_request && (cnt_q == '0) && any_vld;
    Grant_OUT = issue_ok ? (NUM_REQ'(1) << win_idx) : '0;
  end

  logic             issue_vld_p1;
  logic [SEL_W-1:0] issue_sel_p1;
  logic [AGE_W-1:0] issue_age_p1;

  // Issue register feeding the EXE operand mux; freezes with EXE on stall.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      issue_vld_p1 <= 1'b0;
      issue_sel_p1 <= '0;
      issue_age_p1 <= '0;
    end else if (Flush_IN) begin
      issue_vld_p1 <= 1'b0;
    end else if (!IF_stall_request) begin
      issue_vld_p1 <= issue_ok;
      if (issue_ok) begin
        issue_sel_p1 <= win_idx;
        issue_age_p1 <= win_age;
      end
    end
  end

  assign Issue_Valid_OUT = issue_vld_p1;
  assign Issue_Sel_OUT   = issue_sel_p1;
  assign Issue_Age_OUT   = issue_age_p1;

endmodule

// File: tb/tb_exe_issue_select.sv
// Self-checking bench for exe_issue_select: directed scenarios plus randomized traffic.
module tb_exe_issue_select;

  localparam int NUM_REQ    = 4;
  localparam int AGE_W      = 32;
  localparam int MULDIV_LAT = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*AGE_W-1:0] req_age = '0;
  logic [NUM_REQ-1:0]       req_muldiv = '0;
  logic                     stall = 1'b0;
  logic                     flush = 1'b0;
  logic [NUM_REQ-1:0]       grant;
  logic                     issue_valid;
  logic [1:0]               issue_sel;
  logic [AGE_W-1:0]         issue_age;
  logic                     busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_busy = 0;
  logic       m_vld = 1'b0;
  logic [1:0] m_sel = '0;
  logic [31:0] m_age = '0;

  exe_issue_select #(.NUM_REQ(NUM_REQ), .AGE_W(AGE_W), .MULDIV_LAT(MULDIV_LAT)) dut (
    .CLK              (clk),
    .RESET            (rst),
    .Req_Valid_IN     (req_valid),
    .Req_Age_IN       (req_age),
    .Req_MulDiv_IN    (req_muldiv),
    .IF_stall_request (stall),
    .Flush_IN         (flush),
    .Grant_OUT        (grant),
    .Issue_Valid_OUT  (issue_valid),
    .Issue_Sel_OUT    (issue_sel),
    .Issue_Age_OUT    (issue_age),
    .Busy_OUT         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] age_of(input int i);
    return req_age[i*AGE_W +: AGE_W];
  endfunction

  task automatic set_age(input int i, input logic [31:0] v);
    req_age[i*AGE_W +: AGE_W] = v;
  endtask

  function automatic bit is_older(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return $signed(d) < 0;
  endfunction

  function automatic int model_winner();
    int w;
    w = -1;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_valid[i] && (w < 0 || is_older(age_of(i), age_of(w)))) w = i;
    return w;
  endfunction

  function automatic logic [NUM_REQ-1:0] model_grant();
    int w;
    if (rst || flush || stall || m_busy != 0 || req_valid == '0) return '0;
    w = model_winner();
    return NUM_REQ'(1) << w;
  endfunction

  task automatic model_update();
    logic [NUM_REQ-1:0] g;
    int w;
    g = model_grant();
    if (rst) begin
      m_busy = 0; m_vld = 1'b0; m_sel = '0; m_age = '0;
    end else if (flush) begin
      m_busy = 0; m_vld = 1'b0;
    end else if (!stall) begin
      if (m_busy > 0) begin
        m_busy--; m_vld = 1'b0;
      end else if (g != '0) begin
        w = model_winner();
        m_vld = 1'b1; m_sel = 2'(w); m_age = age_of(w);
        if (req_muldiv[w]) m_busy = MULDIV_LAT - 1;
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  // Advance one clock: model consumes the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b exp 0000", grant); end
      tick();
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", issue_valid); end
      checks++; if (issue_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d exp 0", issue_sel); end
      checks++; if (issue_age !== 32'd0) begin errors++; $display("FAIL reset_age: got %h exp 0", issue_age); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_oldest();
    req_valid = 4'b1011; req_muldiv = '0;
    set_age(3, 10); set_age(2, 1); set_age(1, 7); set_age(0, 12);
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL oldest_grant: got %b exp 0010", grant); end
    tick();
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL oldest_valid: got %b exp 1", issue_valid); end
    checks++; if (issue_sel !== 2'd1) begin errors++; $display("FAIL oldest_sel: got %0d exp 1", issue_sel); end
    checks++; if (issue_age !== 32'd7) begin errors++; $display("FAIL oldest_age: got %0d exp 7", issue_age); end
    req_valid = '0;
  endtask

  task automatic test_wrap_and_tie();
    req_valid = 4'b0011; set_age(0, 32'hFFFF_FFFE); set_age(1, 32'h1);
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b exp 0001", grant); end
    tick();
    req_valid = 4'b1100; set_age(2, 5); set_age(3, 5);
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL tie_grant: got %b exp 0100", grant); end
    tick();
    checks++; if (issue_sel !== 2'd2) begin errors++; $display("FAIL tie_sel: got %0d exp 2", issue_sel); end
    req_valid = '0;
  endtask

  task automatic test_muldiv(input bit with_stall);
    int gap;
    gap = with_stall ? MULDIV_LAT + 2 : MULDIV_LAT;
    req_valid = 4'b0011; req_muldiv = 4'b0001; set_age(0, 100); set_age(1, 200);
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL muldiv_first_grant: got %b exp 0001", grant); end
    tick();
    req_valid = 4'b0010;
    for (int c = 1; c <= gap; c++) begin
      stall = with_stall && (c == 2 || c == 3);
      @(negedge clk);
      checks++;
      if (grant !== ((c == gap) ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL muldiv_gap_grant stall=%0d c=%0d: got %b", with_stall, c, grant);
      end
      checks++;
      if (busy !== (c < gap)) begin
        errors++; $display("FAIL muldiv_busy stall=%0d c=%0d: got %b exp %b", with_stall, c, busy, c < gap);
      end
      tick();
    end
    stall = 1'b0; req_valid = '0; req_muldiv = '0;
    checks++; if (issue_sel !== 2'd1) begin errors++; $display("FAIL muldiv_next_sel: got %0d exp 1", issue_sel); end
  endtask

  task automatic test_flush_busy();
    req_valid = 4'b0011; req_muldiv = 4'b0001; set_age(0, 1); set_age(1, 2);
    @(negedge clk);
    tick();
    req_valid = 4'b0010;
    tick();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL flush_grant: got %b exp 0000", grant); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b exp 0", busy); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", issue_valid); end
    flush = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL flush_release_grant: got %b exp 0010", grant); end
    tick();
    req_valid = '0; req_muldiv = '0;
  endtask

  task automatic test_stall_hold();
    req_valid = 4'b0100; set_age(2, 50);
    @(negedge clk);
    tick();
    req_valid = 4'b1111; stall = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_age(i, $urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL stall_grant c=%0d: got %b exp 0000", c, grant); end
      tick();
      checks++; if (issue_sel !== 2'd2) begin errors++; $display("FAIL stall_sel c=%0d: got %0d exp 2", c, issue_sel); end
      checks++; if (issue_age !== 32'd50) begin errors++; $display("FAIL stall_age c=%0d: got %0d exp 50", c, issue_age); end
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c=%0d: got %b exp 1", c, issue_valid); end
    end
    stall = 1'b0; req_valid = '0;
  endtask

  task automatic test_back_to_back();
    req_muldiv = '0; req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NUM_REQ; i++) set_age(i, 1000 + 32'($urandom_range(0, 20)));
      @(negedge clk);
      checks++; if (grant !== model_grant() || grant == '0) begin errors++; $display("FAIL b2b_grant c=%0d: got %b exp %b", c, grant, model_grant()); end
      tick();
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid c=%0d: got %b exp 1", c, issue_valid); end
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [31:0]        base;
    logic [NUM_REQ-1:0] eg;
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 7) == 0);
      req_valid = NUM_REQ'($urandom);
      base = $urandom;
      for (int i = 0; i < NUM_REQ; i++) begin
        set_age(i, base + 32'($urandom_range(0, 6)) - 32'd3);
        req_muldiv[i] = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      eg = model_grant();
      checks++; if (grant !== eg) begin errors++; $display("FAIL rand_grant c=%0d: got %b exp %b", c, grant, eg); end
      tick();
      checks++; if (issue_valid !== m_vld) begin errors++; $display("FAIL rand_valid c=%0d: got %b exp %b", c, issue_valid, m_vld); end
      checks++; if (issue_sel !== m_sel) begin errors++; $display("FAIL rand_sel c=%0d: got %0d exp %0d", c, issue_sel, m_sel); end
      checks++; if (issue_age !== m_age) begin errors++; $display("FAIL rand_age c=%0d: got %h exp %h", c, issue_age, m_age); end
      checks++; if (busy !== (m_busy != 0)) begin errors++; $display("FAIL rand_busy c=%0d: got %b exp %b", c, busy, m_busy != 0); end
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0; req_valid = '0; req_muldiv = '0;
  endtask

  initial begin
    test_reset();
    test_oldest();
    test_wrap_and_tie();
    test_muldiv(1'b0);
    test_muldiv(1'b1);
    test_flush_busy();
    test_stall_hold();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
